// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_MAX     = 9999;
  localparam logic [15:0] BCD_SAT     = 16'h9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_DIGIT_W'(5)) begin
      d_o = d_i + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, start/done handshake.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_W   = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [IN_W-1:0]               bin_in,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int unsigned SW    = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);

  state_e state_q, state_d;

  logic [IN_W-1:0]  bin_q, bin_d;
  logic [SW-1:0]    scr_q, scr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [SW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             load_en;
  logic             shift_en;
  logic             finish;
  logic [SW-1:0]    scr_adj;
  logic [SW+IN_W-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (scr_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == SHIFT);
    load_en  = (state_q == IDLE) && start;
    shift_en = (state_q == SHIFT);
    finish   = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
  end

  // Correction happens on the digits before the shift; overflowing thousands bits fall off the top.
  assign shifted = {scr_adj, bin_q} << 1;

  always_comb begin
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    if (load_en) begin
      bin_d      = bin_in;
      scr_d      = '0;
      cnt_d      = CNT_W'(IN_W);
      ovf_pend_d = (32'(bin_in) > BCD_MAX);
    end else if (shift_en) begin
      {scr_d, bin_d} = shifted;
      cnt_d          = cnt_q - CNT_W'(1);
      if (finish) begin
        done_d = 1'b1;
        if (ovf_pend_q) begin
          bcd_d = SW'(BCD_SAT);
          ovf_d = 1'b1;
        end else begin
          bcd_d = shifted[SW+IN_W-1:IN_W];
          ovf_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, a monitor checks on done.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned n_done = 0;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic [13:0] src;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(
    .IN_W   (14),
    .DIGITS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got bcd %0h ovf %0b, expected no done", bcd_out, ovf);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("bcd(%0d)", mon_e.src), 32'(bcd_out), 32'(mon_e.bcd));
        check($sformatf("ovf(%0d)", mon_e.src), 32'(ovf), 32'(mon_e.ovf));
      end
    end
  end

  // Called #1 after an edge; returns edges elapsed until done and busy samples seen.
  task automatic wait_done(output int unsigned lat, output int unsigned bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_one(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    int unsigned lat, bcnt;
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = v;
    sb.push_back('{bcd: eb, ovf: eo, src: v});
    @(posedge clk); #1;
    start  = 1'b0;
    bin_in = 14'($urandom);
    wait_done(lat, bcnt);
    check($sformatf("latency(%0d)", v), lat, 14);
    check($sformatf("busy_cycles(%0d)", v), bcnt, 14);
    @(posedge clk); #1;
    check($sformatf("done_width(%0d)", v), 32'(done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned lat, bcnt, d0, k, hits;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_bcd", 32'(bcd_out), 0);
    check("reset_ovf", 32'(ovf), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);

    run_one(14'd1234,  16'h1234, 1'b0);
    run_one(14'd0,     16'h0000, 1'b0);
    run_one(14'd9999,  16'h9999, 1'b0);
    run_one(14'd5,     16'h0005, 1'b0);
    run_one(14'd1000,  16'h1000, 1'b0);
    run_one(14'd10000, 16'h9999, 1'b1);
    run_one(14'd42,    16'h0042, 1'b0);
    run_one(14'd16383, 16'h9999, 1'b1);

    // start hammered while busy with changing data: only 777 is converted
    d0 = n_done;
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = 14'd777;
    sb.push_back('{bcd: 16'h0777, ovf: 1'b0, src: 14'd777});
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      start  = 1'b1;
      bin_in = 14'(100 + i * 37);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done(lat, bcnt);
    check("pulsed_latency", lat, 2);
    repeat (20) @(posedge clk);
    #1 check("pulsed_done_count", n_done - d0, 1);

    // start held high: one conversion every 15 cycles
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = 14'h0A5A;
    for (int i = 0; i < 3; i++) sb.push_back('{bcd: 16'h2650, ovf: 1'b0, src: 14'h0A5A});
    @(posedge clk); #1;
    k    = 0;
    hits = 0;
    while (hits < 3 && k < 80) begin
      @(posedge clk); #1;
      k++;
      if (done) begin
        hits++;
        check($sformatf("b2b_done_pos%0d", hits), k, 14 + 15 * (hits - 1));
        if (hits == 3) start = 1'b0;
      end
    end
    check("b2b_done_count", hits, 3);
    repeat (3) @(posedge clk);

    // reset in the middle of a conversion
    run_one(14'd4321, 16'h4321, 1'b0);
    d0 = n_done;
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = 14'd8765;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_out), 0);
    check("abort_ovf", 32'(ovf), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    check("abort_idle_busy", 32'(busy), 0);
    run_one(14'd8765, 16'h8765, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
